time_unit_counter: RTL and testbench

//  Parametrised modulo-N time-unit counter for the clock datapath (seconds, minutes, hours).

---
 rtl/clock_pkg.sv | 19 +
 rtl/rise_edge_det.sv | 19 +
 rtl/time_unit_counter.sv | 112 +++++++++++
 tb/tb_time_unit_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath: per-unit modulos, counter FSM
// states, and the binary-to-BCD helper used by the optional BCD outputs.
package clock_pkg;

  localparam int SEC_MODULO  = 60;
  localparam int MIN_MODULO  = 60;
  localparam int HOUR_MODULO = 24;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_ADJUST = 1'b1
  } cnt_state_t;

  // Packs {tens, units} of a 0..99 binary value; the constant divisor keeps it a small ROM-like block.
  function automatic logic [7:0] bin_to_bcd(input logic [7:0] bin);
    return {4'(bin / 8'd10), 4'(bin % 8'd10)};
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Single-bit rising-edge detector: pulses for one cycle when d_i goes 0 -> 1.
// The history register clears on reset, so a level already high at release reads as an edge.
module rise_edge_det (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic edge_o
);

  logic level_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) level_q <= 1'b0;
    else         level_q <= d_i;
  end

  assign edge_o = d_i & ~level_q;

endmodule

// File: rtl/time_unit_counter.sv
// Chainable modulo-MODULO time-unit counter with RUN/ADJUST modes and direct load.
// Optional BCD outputs are compiled in when the macro BCD_OUT_EN is defined.
module time_unit_counter
  import clock_pkg::*;
#(
  parameter  int MODULO = SEC_MODULO,
  localparam int WIDTH  = $clog2(MODULO)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             tick_i,
  input  logic             adj_mode_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_o,
  output logic             adj_o
`ifdef BCD_OUT_EN
  ,
  output logic [3:0]       bcd_tens_o,
  output logic [3:0]       bcd_units_o
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  if (MODULO < 2 || MODULO > 256) begin : g_bad_modulo
    $error("time_unit_counter: MODULO must be in 2..256");
  end

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             inc_e, dec_e;

  rise_edge_det u_inc_edge (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (inc_i),
    .edge_o (inc_e)
  );

  rise_edge_det u_dec_edge (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (dec_i),
    .edge_o (dec_e)
  );

  // Priority: load, then adjust edges (ADJUST only), then tick (RUN only).
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = adj_mode_i ? ST_ADJUST : ST_RUN;
    value_d = value_q;
    carry_d = 1'b0;

    if (load_i) begin
      value_d = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;
    end else if (state_q == ST_ADJUST) begin
      if (inc_e && !dec_e) begin
        value_d = (value_q == MAX_VAL) ? '0 : value_q + ONE;
      end else if (dec_e && !inc_e) begin
        value_d = (value_q == '0) ? MAX_VAL : value_q - ONE;
      end
    end else if (tick_i) begin
      if (value_q == MAX_VAL) begin
        value_d = '0;
        carry_d = 1'b1;
      end else begin
        value_d = value_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rstn_i) begin
      state_q <= ST_RUN;
      value_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

  assign value_o = value_q;
  assign carry_o = carry_q;
  assign adj_o   = (state_q == ST_ADJUST);

`ifdef BCD_OUT_EN
  if (MODULO > 100) begin : g_bad_bcd_modulo
    $error("time_unit_counter: MODULO must not exceed 100 with BCD_OUT_EN");
  end

  logic [7:0] bcd_q;

  // Fed from value_d so the BCD digits change on the same edge as value_o.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) bcd_q <= '0;
    else         bcd_q <= bin_to_bcd(8'(value_d));
  end

  assign bcd_tens_o  = bcd_q[7:4];
  assign bcd_units_o = bcd_q[3:0];
`endif

endmodule

// File: tb/tb_time_unit_counter.sv
// Self-checking bench for time_unit_counter (MODULO=60 and MODULO=24 instances sharing controls).
module tb_time_unit_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, tick, adj_mode, inc, dec, load;
  logic [5:0] lval;
  logic [4:0] lval24;
  logic [5:0] v60;
  logic       c60, a60;
  logic [4:0] v24;
  logic       c24, a24;
`ifdef BCD_OUT_EN
  logic [3:0] t60, u60, t24, u24;
`endif

  time_unit_counter #(.MODULO(60)) dut60 (
    .clk_i(clk), .rstn_i(rstn), .tick_i(tick), .adj_mode_i(adj_mode),
    .inc_i(inc), .dec_i(dec), .load_i(load), .load_val_i(lval),
    .value_o(v60), .carry_o(c60), .adj_o(a60)
`ifdef BCD_OUT_EN
    , .bcd_tens_o(t60), .bcd_units_o(u60)
`endif
  );

  time_unit_counter #(.MODULO(24)) dut24 (
    .clk_i(clk), .rstn_i(rstn), .tick_i(tick), .adj_mode_i(adj_mode),
    .inc_i(inc), .dec_i(dec), .load_i(load), .load_val_i(lval24),
    .value_o(v24), .carry_o(c24), .adj_o(a24)
`ifdef BCD_OUT_EN
    , .bcd_tens_o(t24), .bcd_units_o(u24)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counter as a plain integer with modular arithmetic.
  typedef struct {
    int val;
    bit carry;
    bit in_adj;
    bit prev_inc;
    bit prev_dec;
  } model_t;

  model_t m60, m24;

  function automatic model_t model_step(model_t m, int modulo, bit r, bit t, bit a,
                                        bit i, bit d, bit l, int lv);
    model_t n;
    bit ie, de;
    if (!r) begin
      n.val = 0; n.carry = 0; n.in_adj = 0; n.prev_inc = 0; n.prev_dec = 0;
      return n;
    end
    ie = i && !m.prev_inc;
    de = d && !m.prev_dec;
    n = m;
    n.prev_inc = i;
    n.prev_dec = d;
    n.in_adj   = a;
    n.carry    = 0;
    if (l) begin
      n.val = (lv < modulo) ? lv : modulo - 1;
    end else if (m.in_adj) begin
      if (ie && !de) n.val = (m.val + 1) % modulo;
      else if (de && !ie) n.val = (m.val + modulo - 1) % modulo;
    end else if (t) begin
      n.carry = (m.val == modulo - 1);
      n.val   = (m.val + 1) % modulo;
    end
    return n;
  endfunction

  task automatic apply(input bit r, input bit t, input bit a, input bit i,
                       input bit d, input bit l, input int lv);
    rstn = r; tick = t; adj_mode = a; inc = i; dec = d; load = l;
    lval   = 6'(lv);
    lval24 = 5'(lv);
    m60 = model_step(m60, 60, r, t, a, i, d, l, int'(lval));
    m24 = model_step(m24, 24, r, t, a, i, d, l, int'(lval24));
    @(posedge clk);
    #1;
  endtask

  task automatic check60(input string tag, input int ev, input bit ec, input bit ea);
    check({tag, "_value"}, int'(v60), ev);
    check({tag, "_carry"}, int'(c60), int'(ec));
    check({tag, "_adj"},   int'(a60), int'(ea));
`ifdef BCD_OUT_EN
    check({tag, "_bcd_tens"},  int'(t60), ev / 10);
    check({tag, "_bcd_units"}, int'(u60), ev % 10);
`endif
  endtask

  typedef struct {
    bit rstn, tick, adj, inc, dec, load;
    int lval;
    int exp_val;
    bit exp_carry, exp_adj;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(bit r, bit t, bit a, bit i, bit d, bit l, int lv,
                                  int ev, bit ec, bit ea);
    vec_t v;
    v.rstn = r; v.tick = t; v.adj = a; v.inc = i; v.dec = d; v.load = l;
    v.lval = lv; v.exp_val = ev; v.exp_carry = ec; v.exp_adj = ea;
    vecs.push_back(v);
  endfunction

  initial begin
    int  carries;
    bit  mode;

    // Adjust, priority and load vectors, starting from value 0 in RUN.
    add_vec(1,0,1,0,0,0, 0,  0,0,1);
    add_vec(1,0,1,0,1,0, 0, 59,0,1);   // dec wraps 0 -> 59
    add_vec(1,0,1,0,0,0, 0, 59,0,1);
    for (int k = 0; k < 10; k++) add_vec(1,0,1,1,0,0,0, 0,0,1);  // held inc: one step
    add_vec(1,0,1,0,0,0, 0,  0,0,1);
    add_vec(1,0,1,1,1,0, 0,  0,0,1);   // simultaneous edges cancel
    add_vec(1,0,1,0,0,0, 0,  0,0,1);
    for (int k = 0; k < 20; k++) add_vec(1,1,1,0,0,0,0, 0,0,1);  // ticks lost in ADJUST
    add_vec(1,1,0,0,0,0, 0,  0,0,0);   // still ADJUST this cycle
    add_vec(1,1,0,0,0,0, 0,  1,0,0);
    add_vec(1,1,0,0,0,0, 0,  2,0,0);
    add_vec(1,0,1,0,0,0, 0,  2,0,1);
    add_vec(1,1,1,1,0,1,45, 45,0,1);   // load beats inc edge and tick
    add_vec(1,0,1,0,0,0, 0, 45,0,1);
    add_vec(1,0,0,0,0,1,63, 59,0,0);   // load saturates
    add_vec(1,1,0,0,0,0, 0,  0,1,0);
    add_vec(1,0,0,0,0,0, 0,  0,0,0);
    add_vec(1,1,0,0,0,1,58, 58,0,0);
    add_vec(1,1,0,0,0,0, 0, 59,0,0);
    add_vec(1,1,0,0,0,1,10, 10,0,0);   // load at max with tick: no carry
    add_vec(1,1,0,1,0,0, 0, 11,0,0);   // inc edge ignored in RUN
    add_vec(1,0,1,0,0,0, 0, 11,0,1);
    add_vec(1,0,1,1,0,0, 0, 12,0,1);
    add_vec(1,0,1,1,0,0, 0, 12,0,1);
    add_vec(0,1,1,1,0,0, 0,  0,0,0);   // reset mid-adjust
    add_vec(1,0,1,1,0,0, 0,  0,0,1);   // edge on release lands in RUN
    add_vec(1,0,1,1,0,0, 0,  0,0,1);

    m60 = '{default: 0};
    m24 = '{default: 0};

    // Reset held two cycles with tick active.
    apply(0,1,0,0,0,0,0);
    apply(0,1,0,0,0,0,0);
    check60("reset", 0, 0, 0);

    // 60 ticks: value climbs and carries on the 60th only.
    for (int k = 0; k < 60; k++) begin
      apply(1,1,0,0,0,0,0);
      check($sformatf("run1_value_%0d", k), int'(v60), (k + 1) % 60);
      check($sformatf("run1_carry_%0d", k), int'(c60), (k == 59) ? 1 : 0);
    end
    apply(1,0,0,0,0,0,0);
    check60("idle_after_wrap", 0, 0, 0);
    carries = 0;
    for (int k = 0; k < 60; k++) begin
      apply(1,1,0,0,0,0,0);
      carries += int'(c60);
      if (k == 58) check("run2_value_59", int'(v60), 59);
    end
    check("run2_value_wrapped", int'(v60), 0);
    check("run2_carry_count", carries, 1);
    check("run2_carry_last", int'(c60), 1);
    apply(1,0,0,0,0,0,0);
    check("run2_carry_drops", int'(c60), 0);

    foreach (vecs[k]) begin
      apply(vecs[k].rstn, vecs[k].tick, vecs[k].adj, vecs[k].inc,
            vecs[k].dec, vecs[k].load, vecs[k].lval);
      check60($sformatf("vec%0d", k), vecs[k].exp_val, vecs[k].exp_carry, vecs[k].exp_adj);
    end

    // Randomised traffic on both instances against the model.
    apply(0,0,0,0,0,0,0);
    apply(0,0,0,0,0,0,0);
    mode = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      apply($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), mode,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, int'($urandom_range(0, 63)));
      check("rnd60_value", int'(v60), m60.val);
      check("rnd60_carry", int'(c60), int'(m60.carry));
      check("rnd60_adj",   int'(a60), int'(m60.in_adj));
      check("rnd24_value", int'(v24), m24.val);
      check("rnd24_carry", int'(c24), int'(m24.carry));
      check("rnd24_adj",   int'(a24), int'(m24.in_adj));
`ifdef BCD_OUT_EN
      check("rnd24_bcd_tens",  int'(t24), m24.val / 10);
      check("rnd24_bcd_units", int'(u24), m24.val % 10);
      check("rnd60_bcd_tens",  int'(t60), m60.val / 10);
      check("rnd60_bcd_units", int'(u60), m60.val % 10);
`endif
    end

    // MODULO=24 wrap: load 23, tick -> 0 with carry, then reset clears everything.
    apply(1,0,0,0,0,1,23);
    check("m24_load23", int'(v24), 23);
    apply(1,1,0,0,0,0,0);
    check("m24_wrap_value", int'(v24), 0);
    check("m24_wrap_carry", int'(c24), 1);
    apply(1,1,0,0,0,0,0);
    check("m24_after_wrap", int'(v24), 1);
    apply(0,1,0,0,0,0,0);
    check("m24_reset_value", int'(v24), 0);
    check("m24_reset_carry", int'(c24), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
